// File: rtl/serial_adder_n_if.sv
`default_nettype none
//============================================================================
// Module   : serial_adder_n_if
// Brief    : Request/result bundle for the digit-serial adder/subtractor.
// Revision : 1.0 - initial release
//============================================================================
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
//============================================================================
// Module   : serial_adder_n
// Brief    : Digit-serial adder/subtractor, LSB-first, WIDTH/DIGIT cycles.
// Revision : 1.0 - initial release
//============================================================================
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_adder_n_if.slave  bus
);

    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic               w_run;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_dsum;
    logic               w_cmsb;
    logic               w_cout;
    logic [WIDTH-1:0]   w_acc_nxt;

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                w_run = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // DIGIT-bit ripple of full-adder slices; also exposes the carry into the top slice
    always_comb begin : p_ripple
        logic v_carry;
        v_carry = r_carry;
        w_dsum  = '0;
        w_cmsb  = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            w_cmsb    = v_carry;
            w_dsum[i] = r_a[i] ^ r_b[i] ^ v_carry;
            v_carry   = (r_a[i] & r_b[i]) | (v_carry & (r_a[i] ^ r_b[i]));
        end
        w_cout = v_carry;
    end

    // The new digit enters at the MSB end, so after N digits the result is aligned
    generate
        if (c_N == 1) begin : g_single
            assign w_acc_nxt = w_dsum;
        end else begin : g_multi
            assign w_acc_nxt = {w_dsum, r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.sub ? ~bus.b : bus.b;
                r_carry <= bus.sub ? 1'b1 : bus.cin;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else if (w_run) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_acc   <= w_acc_nxt;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                // Visible results change only once the whole word is done
                if (w_last) begin
                    r_sum  <= w_acc_nxt;
                    r_cout <= w_cout;
                    r_ovf  <= w_cmsb ^ w_cout;
                end
            end
        end
    end

    assign bus.busy = (r_state != c_IDLE);
    assign bus.done = (r_state == c_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`default_nettype none
//============================================================================
// Module   : tb_serial_adder_n
// Brief    : Self-checking bench for serial_adder_n over four configurations.
// Revision : 1.0 - initial release
//============================================================================
module tb_serial_adder_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Unit 0: W8/D1, 1: W8/D4, 2: W4/D1, 3: W4/D2
    serial_adder_n_if #(.WIDTH(8)) if8d1 ();
    serial_adder_n_if #(.WIDTH(8)) if8d4 ();
    serial_adder_n_if #(.WIDTH(4)) if4d1 ();
    serial_adder_n_if #(.WIDTH(4)) if4d2 ();

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_8d1 (.clk(clk), .rst(rst), .bus(if8d1));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_8d4 (.clk(clk), .rst(rst), .bus(if8d4));
    serial_adder_n #(.WIDTH(4), .DIGIT(1)) u_4d1 (.clk(clk), .rst(rst), .bus(if4d1));
    serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_4d2 (.clk(clk), .rst(rst), .bus(if4d2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unit_w(input int u);
        return (u < 2) ? 8 : 4;
    endfunction

    function automatic int unit_n(input int u);
        case (u)
            0:       return 8;
            1:       return 2;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    task automatic drive(input int u, input logic st, input logic sb,
                         input logic [7:0] av, input logic [7:0] bv, input logic ci);
        case (u)
            0: begin if8d1.start = st; if8d1.sub = sb; if8d1.a = av;      if8d1.b = bv;      if8d1.cin = ci; end
            1: begin if8d4.start = st; if8d4.sub = sb; if8d4.a = av;      if8d4.b = bv;      if8d4.cin = ci; end
            2: begin if4d1.start = st; if4d1.sub = sb; if4d1.a = av[3:0]; if4d1.b = bv[3:0]; if4d1.cin = ci; end
            default: begin if4d2.start = st; if4d2.sub = sb; if4d2.a = av[3:0]; if4d2.b = bv[3:0]; if4d2.cin = ci; end
        endcase
    endtask

    task automatic drive_noise(input int u);
        drive(u, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    function automatic logic [7:0] rd_sum(input int u);
        case (u)
            0:       return if8d1.sum;
            1:       return if8d4.sum;
            2:       return {4'h0, if4d1.sum};
            default: return {4'h0, if4d2.sum};
        endcase
    endfunction

    // {busy, done, cout, ovf}
    function automatic logic [3:0] rd_flags(input int u);
        case (u)
            0:       return {if8d1.busy, if8d1.done, if8d1.cout, if8d1.ovf};
            1:       return {if8d4.busy, if8d4.done, if8d4.cout, if8d4.ovf};
            2:       return {if4d1.busy, if4d1.done, if4d1.cout, if4d1.ovf};
            default: return {if4d2.busy, if4d2.done, if4d2.cout, if4d2.ovf};
        endcase
    endfunction

    // Reference: plain integer arithmetic, overflow from signed range
    task automatic ref_model(input int w, input logic sb, input logic [7:0] av,
                             input logic [7:0] bv, input logic ci,
                             output logic [7:0] s, output logic co, output logic ov);
        int mask;
        int half;
        int ai;
        int bi;
        int r;
        int sa;
        int sbv;
        int sr;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ai   = int'(av) & mask;
        bi   = int'(bv) & mask;
        r    = sb ? (ai - bi + (1 << w)) : (ai + bi + int'(ci));
        s    = 8'(r & mask);
        co   = 1'((r >> w) & 1);
        sa   = (ai >= half) ? ai - (1 << w) : ai;
        sbv  = (bi >= half) ? bi - (1 << w) : bi;
        sr   = sb ? (sa - sbv) : (sa + sbv + int'(ci));
        ov   = (sr < -half) || (sr > half - 1);
    endtask

    // Called just after the accept edge; returns cycles to done and busy samples seen
    task automatic wait_done(input int u, output int lat, output int bcnt);
        logic [3:0] f;
        lat  = 0;
        bcnt = 0;
        f    = rd_flags(u);
        while (!f[2] && lat < 40) begin
            if (f[3]) bcnt++;
            tick();
            lat++;
            f = rd_flags(u);
        end
        if (f[3]) bcnt++;
    endtask

    task automatic check_result(input int u, input string tag, input logic sb,
                                input logic [7:0] av, input logic [7:0] bv, input logic ci);
        logic [7:0] es;
        logic       ec;
        logic       eo;
        logic [3:0] f;
        ref_model(unit_w(u), sb, av, bv, ci, es, ec, eo);
        f = rd_flags(u);
        check({tag, "_sum"},  32'(rd_sum(u)), 32'(es));
        check({tag, "_cout"}, 32'(f[1]), 32'(ec));
        check({tag, "_ovf"},  32'(f[0]), 32'(eo));
    endtask

    task automatic run_op(input int u, input logic sb, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci, input string tag);
        int         lat;
        int         bcnt;
        logic [3:0] f;
        drive(u, 1'b1, sb, av, bv, ci);
        tick();
        drive_noise(u);
        wait_done(u, lat, bcnt);
        check({tag, "_lat"}, 32'(lat), 32'(unit_n(u)));
        check_result(u, tag, sb, av, bv, ci);
        tick();
        f = rd_flags(u);
        check({tag, "_end"},  32'(f[3:2]), 32'd0);
        check({tag, "_busy"}, 32'(bcnt), 32'(unit_n(u) + 1));
    endtask

    initial begin
        logic [3:0] f;
        logic [7:0] a1;
        logic [7:0] b1;
        logic [7:0] a2;
        logic [7:0] b2;
        logic       s1;
        logic       s2;
        logic       c1;
        logic       c2;
        logic       seen;
        int         lat;
        int         bcnt;

        for (int u = 0; u < 4; u++) drive(u, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int u = 0; u < 4; u++) begin
            f = rd_flags(u);
            check($sformatf("reset_flags_u%0d", u), 32'(f), 32'd0);
            check($sformatf("reset_sum_u%0d", u), 32'(rd_sum(u)), 32'd0);
        end

        // Directed cases
        run_op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, "d_5a3c");
        run_op(0, 1'b0, 8'hFF, 8'h01, 1'b1, "d_ff01");
        run_op(0, 1'b1, 8'h10, 8'h20, 1'b1, "d_sub");
        run_op(1, 1'b0, 8'h7F, 8'h01, 1'b0, "d4_7f01");
        run_op(1, 1'b1, 8'h00, 8'h01, 1'b0, "d4_sub");

        // Random operations on the 8-bit units
        for (int k = 0; k < 60; k++)
            run_op(k % 2, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "rnd");

        // start held high; operands swapped mid-RUN become the next operation
        a1 = 8'($urandom); b1 = 8'($urandom); s1 = 1'($urandom); c1 = 1'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom); s2 = 1'($urandom); c2 = 1'($urandom);
        drive(0, 1'b1, s1, a1, b1, c1);
        tick();
        f = rd_flags(0);
        check("hold_acc1", 32'(f[3]), 32'd1);
        drive(0, 1'b1, s2, a2, b2, c2);
        wait_done(0, lat, bcnt);
        check("hold_lat1", 32'(lat), 32'd8);
        check_result(0, "hold_op1", s1, a1, b1, c1);
        tick();
        f = rd_flags(0);
        check("hold_gap", 32'(f[3:2]), 32'd0);
        tick();
        f = rd_flags(0);
        check("hold_acc2", 32'(f[3]), 32'd1);
        drive_noise(0);
        wait_done(0, lat, bcnt);
        check("hold_lat2", 32'(lat), 32'd8);
        check_result(0, "hold_op2", s2, a2, b2, c2);
        tick();

        // Reset in the middle of RUN discards the operation
        run_op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, "pre_rst");
        drive(0, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0);
        tick();
        drive_noise(0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        f = rd_flags(0);
        check("rst_flags", 32'(f), 32'd0);
        check("rst_sum", 32'(rd_sum(0)), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            f = rd_flags(0);
            if (f[2] || f[3]) seen = 1'b1;
        end
        check("rst_quiet", 32'(seen), 32'd0);
        run_op(0, 1'b0, 8'h33, 8'h44, 1'b1, "post_rst");

        // Exhaustive 4-bit sweep, operand order randomized per unit
        for (int u = 2; u < 4; u++) begin
            int base;
            base = int'($urandom_range(0, 1023));
            for (int i = 0; i < 1024; i++) begin
                int v;
                v = (i + base) % 1024;
                run_op(u, 1'(v >> 9), 8'(v & 15), 8'((v >> 4) & 15), 1'((v >> 8) & 1), "exh");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
